// File: rtl/qsys_pio_seq_if.sv
// Avalon-MM slave bus bundle for qsys_pio_seq: register select, write strobe, data in/out.
interface qsys_pio_seq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/qsys_pio_seq.sv
// Register-programmed 4-step pattern sequencer driving out_port with per-step dwell.
// Define QSYS_PIO_SEQ_IRQ_EN to build the done interrupt and CONTROL.irq_en.
module qsys_pio_seq (
    input  logic          clk,
    input  logic          reset_n,
    qsys_pio_seq_if.slave bus,
    output logic [3:0]    out_port,
    output logic          irq
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  r_state;
    logic        r_loop;
    logic [23:0] r_period;
    logic [1:0]  r_length;
    logic [3:0]  r_pat [4];
    logic [23:0] r_cnt;
    logic [1:0]  r_step;
    logic        r_done;
    logic [3:0]  r_out;

    logic w_wr;
    logic w_wr_ctrl;
    logic w_wr_status;
    logic w_busy;
    logic w_abort;
    logic w_last;
    logic w_finish;
    logic w_irq_en;
    logic w_unused_wdata;

    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_wr_ctrl   = w_wr && (bus.address == 3'd0);
    assign w_wr_status = w_wr && (bus.address == 3'd3);
    assign w_busy      = (r_state == RUN);
    assign w_abort     = w_busy && w_wr_ctrl && !bus.writedata[0];
    // ">=" so a LENGTH lowered below the current step ends/wraps at the next transition
    assign w_last      = (r_step >= r_length);
    assign w_finish    = w_busy && !w_abort && (r_cnt == 24'd0) && w_last && !r_loop;
    assign w_unused_wdata = &{1'b0, bus.writedata[31:24]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loop   <= 1'b0;
            r_period <= '0;
            r_length <= '0;
            for (int unsigned i = 0; i < 4; i++) r_pat[i] <= '0;
        end else if (w_wr) begin
            case (bus.address)
                3'd0:    r_loop   <= bus.writedata[1];
                3'd1:    r_period <= bus.writedata[23:0];
                3'd2:    r_length <= bus.writedata[1:0];
                3'd3:    ;
                default: r_pat[bus.address[1:0]] <= bus.writedata[3:0];
            endcase
        end
    end

`ifdef QSYS_PIO_SEQ_IRQ_EN
    logic r_irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_irq_en <= 1'b0;
        else if (w_wr_ctrl) r_irq_en <= bus.writedata[2];
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_done && r_irq_en;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_step  <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_ctrl && bus.writedata[0]) begin
                        r_state <= RUN;
                        r_step  <= '0;
                        r_out   <= r_pat[0];
                        r_cnt   <= r_period;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else if (r_cnt != 24'd0) begin
                        r_cnt <= r_cnt - 24'd1;
                    end else if (!w_last) begin
                        r_step <= r_step + 2'd1;
                        r_out  <= r_pat[r_step + 2'd1];
                        r_cnt  <= r_period;
                    end else if (r_loop) begin
                        r_step <= '0;
                        r_out  <= r_pat[0];
                        r_cnt  <= r_period;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion set takes priority over a same-cycle W1C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                r_done <= 1'b0;
        else if (w_finish)                           r_done <= 1'b1;
        else if (w_wr_status && bus.writedata[1])    r_done <= 1'b0;
    end

    assign out_port = r_out;

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata = {29'd0, w_irq_en, r_loop, w_busy};
            3'd1:    bus.readdata = {8'd0, r_period};
            3'd2:    bus.readdata = {30'd0, r_length};
            3'd3:    bus.readdata = {26'd0, r_step, 2'b00, r_done, w_busy};
            default: bus.readdata = {28'd0, r_pat[bus.address[1:0]]};
        endcase
    end

endmodule

// File: tb/tb_qsys_pio_seq.sv
// Self-checking bench for qsys_pio_seq: directed scenarios plus randomized runs
// checked against a trajectory model built from pattern/period/length settings.
module tb_qsys_pio_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] out_port;
    logic       irq;

    qsys_pio_seq_if bus ();

    qsys_pio_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: programmed register contents and sticky flags
    logic [3:0] m_pat [4];
    int         m_period;
    int         m_len;
    logic       m_loop;
    logic       m_irq_en;
    logic       m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pat[i] = 4'h0;
        m_period = 0;
        m_len    = 0;
        m_loop   = 1'b0;
        m_irq_en = 1'b0;
        m_done   = 1'b0;
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd3;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    function automatic int exp_step(input int k, input logic lp);
        int s;
        s = k / (m_period + 1);
        if (lp) s = s % (m_len + 1);
        return s;
    endfunction

    function automatic logic [31:0] exp_out(input int k, input logic lp);
        return {28'd0, m_pat[exp_step(k, lp)]};
    endfunction

    function automatic logic [31:0] stat_word(input int step, input logic busy);
        return {26'd0, 2'(step), 2'b00, m_done, busy};
    endfunction

    function automatic logic eff_irq_en();
`ifdef QSYS_PIO_SEQ_IRQ_EN
        return m_irq_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_irq();
        return {31'd0, m_done & eff_irq_en()};
    endfunction

    function automatic logic [31:0] ctrl_word(input logic busy);
        return {29'd0, eff_irq_en(), m_loop, busy};
    endfunction

    // Single non-looping run from IDLE, checked cycle by cycle through completion
    task automatic run_once(input string tag);
        logic [31:0] d;
        int total;
        m_loop = 1'b0;
        wr(3'd0, {29'd0, m_irq_en, 1'b0, 1'b1});
        total = (m_len + 1) * (m_period + 1);
        for (int k = 0; k < total; k++) begin
            check({tag, "_out"}, 32'(out_port), exp_out(k, 1'b0));
            rd(3'd3, d);
            check({tag, "_stat"}, d, stat_word(exp_step(k, 1'b0), 1'b1));
            @(negedge clk);
        end
        m_done = 1'b1;
        check({tag, "_end_out"}, 32'(out_port), {28'd0, m_pat[m_len]});
        rd(3'd3, d);
        check({tag, "_end_stat"}, d, stat_word(m_len, 1'b0));
        rd(3'd0, d);
        check({tag, "_end_ctrl"}, d, ctrl_word(1'b0));
        check({tag, "_end_irq"}, 32'(irq), exp_irq());
    endtask

    task automatic set_pats(input logic [3:0] p0, input logic [3:0] p1,
                            input logic [3:0] p2, input logic [3:0] p3);
        wr(3'd4, {28'd0, p0}); m_pat[0] = p0;
        wr(3'd5, {28'd0, p1}); m_pat[1] = p1;
        wr(3'd6, {28'd0, p2}); m_pat[2] = p2;
        wr(3'd7, {28'd0, p3}); m_pat[3] = p3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int p;
        int l;

        reset_n        = 1'b0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state: every register reads zero, outputs idle
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check("reset_rd", d, 32'd0);
        end
        check("reset_out", 32'(out_port), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        @(negedge clk);

        // Basic one-shot: 1,2,4,8 with 3 cycles each
        set_pats(4'h1, 4'h2, 4'h4, 4'h8);
        wr(3'd1, 32'd2); m_period = 2;
        wr(3'd2, 32'd3); m_len = 3;
        rd(3'd1, d); check("period_rd", d, 32'd2);
        rd(3'd2, d); check("length_rd", d, 32'd3);
        run_once("oneshot");
        @(negedge clk);

        // Loop for 20 cycles then abort with run=0
        wr(3'd3, 32'd2); m_done = 1'b0;
        rd(3'd3, d); check("w1c_clear", d, stat_word(3, 1'b0));
        m_loop = 1'b1;
        wr(3'd0, 32'd3);
        for (int k = 0; k < 20; k++) begin
            check("loop_out", 32'(out_port), exp_out(k, 1'b1));
            rd(3'd3, d);
            check("loop_stat", d, stat_word(exp_step(k, 1'b1), 1'b1));
            if (k == 0) begin
                rd(3'd0, d);
                check("loop_ctrl", d, ctrl_word(1'b1));
            end
            if (k < 19) @(negedge clk);
        end
        m_loop = 1'b0;
        wr(3'd0, 32'd0);
        check("abort_out", 32'(out_port), exp_out(19, 1'b1));
        rd(3'd3, d);
        check("abort_stat", d, stat_word(exp_step(19, 1'b1), 1'b0));
        check("abort_irq", 32'(irq), exp_irq());
        @(negedge clk);
        check("abort_hold", 32'(out_port), exp_out(19, 1'b1));

        // 1-cycle steps with irq enabled, then W1C clears irq
        wr(3'd1, 32'd0); m_period = 0;
        wr(3'd2, 32'd1); m_len = 1;
        m_irq_en = 1'b1;
        run_once("fast");
        wr(3'd3, 32'd2); m_done = 1'b0;
        rd(3'd3, d); check("fast_w1c", d, stat_word(1, 1'b0));
        check("fast_irq_clr", 32'(irq), exp_irq());

        // W1C in the very cycle done is set: set wins
        wr(3'd0, 32'd5);
        check("coll_k0", 32'(out_port), {28'd0, m_pat[0]});
        @(negedge clk);
        check("coll_k1", 32'(out_port), {28'd0, m_pat[1]});
        wr(3'd3, 32'd2);
        m_done = 1'b1;
        rd(3'd3, d);
        check("coll_done", d, stat_word(1, 1'b0));
        check("coll_irq", 32'(irq), exp_irq());

        // Mid-run PATTERN2 and LENGTH changes
        m_irq_en = 1'b0;
        wr(3'd1, 32'd2); m_period = 2;
        wr(3'd2, 32'd3); m_len = 3;
        wr(3'd0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("mid_s0", 32'(out_port), 32'd1);
            @(negedge clk);
        end
        check("mid_s1a", 32'(out_port), 32'd2);
        wr(3'd6, 32'hF); m_pat[2] = 4'hF;
        check("mid_s1b", 32'(out_port), 32'd2);
        wr(3'd2, 32'd1); m_len = 1;
        check("mid_s1c", 32'(out_port), 32'd2);
        rd(3'd3, d);
        check("mid_s1_stat", d, stat_word(1, 1'b1));
        @(negedge clk);
        m_done = 1'b1;
        check("mid_end_out", 32'(out_port), 32'd2);
        rd(3'd3, d);
        check("mid_end_stat", d, stat_word(1, 1'b0));
        run_once("len1");
        wr(3'd2, 32'd2); m_len = 2;
        run_once("len2");

        // Randomized one-shot runs
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) begin
                d = $urandom;
                wr(3'(4 + i), d);
                m_pat[i] = d[3:0];
                rd(3'(4 + i), d);
                check("rnd_pat_rd", d, {28'd0, m_pat[i]});
            end
            p = $urandom_range(0, 3);
            wr(3'd1, {8'($urandom), 24'(p)}); m_period = p;
            l = $urandom_range(0, 3);
            wr(3'd2, {30'($urandom), 2'(l)}); m_len = l;
            m_irq_en = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wr(3'd3, 32'd2);
                m_done = 1'b0;
            end
            run_once("rnd");
        end

        // Reset asserted mid-run
        wr(3'd1, 32'd3); m_period = 3;
        wr(3'd2, 32'd3); m_len = 3;
        wr(3'd4, 32'h9); m_pat[0] = 4'h9;
        wr(3'd0, 32'd5);
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        bus.address = 3'd3;
        #1;
        check("rst_out", 32'(out_port), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_stat", bus.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(3'd3, d); check("rst_idle_stat", d, 32'd0);
        rd(3'd4, d); check("rst_pat0", d, 32'd0);
        rd(3'd1, d); check("rst_period", d, 32'd0);
        check("rst_idle_out", 32'(out_port), 32'd0);
        @(negedge clk);
        check("rst_idle_out2", 32'(out_port), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
